// File: rtl/ienc.sv
// Instruction encoder: packs decoded RV32I fields into a 32-bit word and writes it
// to instruction memory at an auto-incrementing word address, with sticky error capture.
module ienc #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              restart,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        fmt,
  input  logic [6:0]        cmd_op,
  input  logic [2:0]        func3,
  input  logic [6:0]        func7,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              wrapped,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [1:0] CODE_OK    = 2'd0;
  localparam logic [1:0] CODE_FMT   = 2'd1;
  localparam logic [1:0] CODE_RANGE = 2'd2;
  localparam logic [1:0] CODE_ALIGN = 2'd3;

  logic [31:0]       packed_word;
  logic [1:0]        chk_code;
  logic              accept;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] cnt_base;
  logic              wrapped_base;
  logic              err_base;
  logic [1:0]        code_base;

  // Handshake: a field set transfers on any rising edge where in_valid & in_ready;
  // mem_we is held with stable addr/data until the edge where mem_ready is also 1.
  assign in_ready = !mem_we || mem_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    packed_word = '0;
    case (fmt)
      FMT_R:   packed_word = {func7, rs2, rs1, func3, rd, cmd_op};
      FMT_I:   packed_word = {imm[11:0], rs1, func3, rd, cmd_op};
      FMT_S:   packed_word = {imm[11:5], rs2, rs1, func3, imm[4:0], cmd_op};
      FMT_B:   packed_word = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], cmd_op};
      FMT_U:   packed_word = {imm[31:12], rd, cmd_op};
      FMT_J:   packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, cmd_op};
      default: packed_word = '0;
    endcase
  end

  // Range is checked before alignment so an odd out-of-range offset reports range.
  always_comb begin
    chk_code = CODE_OK;
    case (fmt)
      FMT_R: chk_code = CODE_OK;
      FMT_I, FMT_S: begin
        if (!((&imm[31:11]) || !(|imm[31:11]))) chk_code = CODE_RANGE;
      end
      FMT_B: begin
        if (!((&imm[31:12]) || !(|imm[31:12]))) chk_code = CODE_RANGE;
        else if (imm[0])                        chk_code = CODE_ALIGN;
      end
      FMT_U: begin
        if (|imm[11:0]) chk_code = CODE_RANGE;
      end
      FMT_J: begin
        if (!((&imm[31:20]) || !(|imm[31:20]))) chk_code = CODE_RANGE;
        else if (imm[0])                        chk_code = CODE_ALIGN;
      end
      default: chk_code = CODE_FMT;
    endcase
  end

  // Restart takes effect before a same-cycle accept is recorded.
  always_comb begin
    cnt_base     = restart ? '0    : cnt;
    wrapped_base = restart ? 1'b0  : wrapped;
    err_base     = restart ? 1'b0  : err;
    code_base    = restart ? 2'd0  : err_code;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      wrapped   <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'd0;
    end else begin
      cnt      <= cnt_base;
      wrapped  <= wrapped_base;
      err      <= err_base;
      err_code <= code_base;
      if (mem_we && mem_ready) mem_we <= 1'b0;
      if (accept) begin
        if (chk_code == CODE_OK) begin
          mem_we    <= 1'b1;
          mem_addr  <= cnt_base;
          mem_wdata <= packed_word;
          cnt       <= cnt_base + ADDR_W'(1);
          if (&cnt_base) wrapped <= 1'b1;
        end else begin
          err <= 1'b1;
          if (!err_base) err_code <= chk_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_ienc.sv
// Bench for ienc: table vectors, hand-written corner sequences and a randomized run
// scored against an arithmetic encoder model with an expected-write queue.
module tb_ienc;

  localparam int AW = 8;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] word;
    logic [1:0]  code;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst_n, restart, in_valid, mem_ready;
  logic [2:0]    fmt, func3;
  logic [6:0]    cmd_op, func7;
  logic [4:0]    rd, rs1, rs2;
  logic [31:0]   imm;
  logic          in_ready, mem_we, wrapped, err;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [1:0]    err_code;
  logic          in_ready_s, mem_we_s, wrapped_s, err_s;
  logic [1:0]    mem_addr_s;
  logic [31:0]   mem_wdata_s;
  logic [1:0]    err_code_s;

  int errors = 0;
  int checks = 0;

  logic [AW+31:0] exp_q[$];
  logic [AW-1:0]  m_cnt = '0;
  logic           m_wrapped = 1'b0;
  logic           m_err = 1'b0;
  logic [1:0]     m_code = 2'd0;

  ienc #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .cmd_op(cmd_op), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .wrapped(wrapped), .err(err), .err_code(err_code)
  );

  ienc #(.ADDR_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .restart(restart), .in_valid(in_valid), .in_ready(in_ready_s),
    .fmt(fmt), .cmd_op(cmd_op), .func3(func3), .func7(func7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .mem_we(mem_we_s), .mem_ready(mem_ready), .mem_addr(mem_addr_s),
    .mem_wdata(mem_wdata_s), .wrapped(wrapped_s), .err(err_s), .err_code(err_code_s)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                              input logic [6:0] f7, input logic [4:0] d, input logic [4:0] s1,
                              input logic [4:0] s2, input logic [31:0] im,
                              input logic [31:0] w, input logic [1:0] c);
    vec_t v;
    v.fmt = f; v.op = op; v.f3 = f3; v.f7 = f7; v.rd = d; v.rs1 = s1; v.rs2 = s2;
    v.imm = im; v.word = w; v.code = c;
    return v;
  endfunction

  // reference model: field extraction by shift/modulo, limits as signed ranges
  function automatic longint unsigned fld(input longint unsigned x, input int lo, input int n);
    return (x >> lo) % (64'd1 << n);
  endfunction

  function automatic logic [31:0] ref_word(input vec_t v);
    longint unsigned op, f3, f7, d, s1, s2, im, w;
    op = 64'(v.op); f3 = 64'(v.f3); f7 = 64'(v.f7);
    d = 64'(v.rd); s1 = 64'(v.rs1); s2 = 64'(v.rs2); im = 64'(v.imm);
    case (v.fmt)
      3'd0: w = (f7 << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + op;
      3'd1: w = (fld(im, 0, 12) << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + op;
      3'd2: w = (fld(im, 5, 7) << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12)
                + (fld(im, 0, 5) << 7) + op;
      3'd3: w = (fld(im, 12, 1) << 31) + (fld(im, 5, 6) << 25) + (s2 << 20) + (s1 << 15)
                + (f3 << 12) + (fld(im, 1, 4) << 8) + (fld(im, 11, 1) << 7) + op;
      3'd4: w = (fld(im, 12, 20) << 12) + (d << 7) + op;
      3'd5: w = (fld(im, 20, 1) << 31) + (fld(im, 1, 10) << 21) + (fld(im, 11, 1) << 20)
                + (fld(im, 12, 8) << 12) + (d << 7) + op;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic logic [1:0] ref_code(input vec_t v);
    longint s;
    s = longint'($signed(v.imm));
    if (v.fmt > 3'd5) return 2'd1;
    if ((v.fmt == 3'd1 || v.fmt == 3'd2) && (s < -2048 || s > 2047)) return 2'd2;
    if (v.fmt == 3'd3 && (s < -4096 || s > 4095)) return 2'd2;
    if (v.fmt == 3'd5 && (s < -1048576 || s > 1048575)) return 2'd2;
    if (v.fmt == 3'd4 && (v.imm % 4096) != 0) return 2'd2;
    if ((v.fmt == 3'd3 || v.fmt == 3'd5) && (v.imm % 2) != 0) return 2'd3;
    return 2'd0;
  endfunction

  // scoreboard: inputs are stable at the falling edge, so this sees what the next rising edge does
  always @(negedge clk) begin
    vec_t           cur;
    logic           pending;
    logic           acc;
    logic [1:0]     c;
    logic [AW+31:0] e;
    if (rst_n) begin
      cur = mk(fmt, cmd_op, func3, func7, rd, rs1, rs2, imm, 32'd0, 2'd0);
      pending = (exp_q.size() != 0);
      check("mem_we", 64'(mem_we), 64'(pending));
      check("err", 64'(err), 64'(m_err));
      check("err_code", 64'(err_code), 64'(m_code));
      check("wrapped", 64'(wrapped), 64'(m_wrapped));
      check("in_ready", 64'(in_ready), 64'(!pending || mem_ready));
      acc = in_valid && (!pending || mem_ready);
      if (pending && mem_ready) begin
        e = exp_q.pop_front();
        check("write", 64'({mem_addr, mem_wdata}), 64'(e));
      end
      if (restart) begin
        m_cnt = '0; m_wrapped = 1'b0; m_err = 1'b0; m_code = 2'd0;
      end
      if (acc) begin
        c = ref_code(cur);
        if (c != 2'd0) begin
          if (!m_err) m_code = c;
          m_err = 1'b1;
        end else begin
          exp_q.push_back({m_cnt, ref_word(cur)});
          if (m_cnt == AW'(2**AW - 1)) m_wrapped = 1'b1;
          m_cnt = m_cnt + AW'(1);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    fmt = v.fmt; cmd_op = v.op; func3 = v.f3; func7 = v.f7;
    rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
    in_valid = 1'b1;
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    v = mk(3'($urandom_range(0, 5)), 7'($urandom), 3'($urandom), 7'($urandom),
           5'($urandom), 5'($urandom), 5'($urandom), 32'd0, 32'd0, 2'd0);
    if ($urandom_range(0, 15) == 0) v.fmt = 3'($urandom_range(6, 7));
    case ($urandom_range(0, 3))
      0: v.imm = 32'(int'($urandom_range(0, 4095)) - 2048);
      1: v.imm = $urandom;
      2: v.imm = $urandom & 32'hFFFF_F000;
      default: v.imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
    endcase
    return v;
  endfunction

  vec_t tbl[6];
  vec_t bd[21];
  vec_t v;

  initial begin
    tbl[0] = mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,          32'h0050_0093, 2'd0);
    tbl[1] = mk(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h0020_81B3, 2'd0);
    tbl[2] = mk(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020_A423, 2'd0);
    tbl[3] = mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC,  32'hFE20_8EE3, 2'd0);
    tbl[4] = mk(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000,  32'h1234_52B7, 2'd0);
    tbl[5] = mk(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800,  32'h0010_00EF, 2'd0);

    bd[0]  = mk(3'd1, 7'h13, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd2047,      32'd0, 2'd0);
    bd[1]  = mk(3'd1, 7'h13, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, -32'sd2048,    32'd0, 2'd0);
    bd[2]  = mk(3'd1, 7'h13, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd2048,      32'd0, 2'd2);
    bd[3]  = mk(3'd1, 7'h13, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, -32'sd2049,    32'd0, 2'd2);
    bd[4]  = mk(3'd2, 7'h23, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd2047,      32'd0, 2'd0);
    bd[5]  = mk(3'd2, 7'h23, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, -32'sd2049,    32'd0, 2'd2);
    bd[6]  = mk(3'd3, 7'h63, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd4094,      32'd0, 2'd0);
    bd[7]  = mk(3'd3, 7'h63, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, -32'sd4096,    32'd0, 2'd0);
    bd[8]  = mk(3'd3, 7'h63, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd4096,      32'd0, 2'd2);
    bd[9]  = mk(3'd3, 7'h63, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd4095,      32'd0, 2'd3);
    bd[10] = mk(3'd3, 7'h63, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, -32'sd4097,    32'd0, 2'd2);
    bd[11] = mk(3'd5, 7'h6F, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'h000F_FFFE, 32'd0, 2'd0);
    bd[12] = mk(3'd5, 7'h6F, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'h0010_0000, 32'd0, 2'd2);
    bd[13] = mk(3'd5, 7'h6F, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd1,         32'd0, 2'd3);
    bd[14] = mk(3'd5, 7'h6F, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, -32'sd1048576, 32'd0, 2'd0);
    bd[15] = mk(3'd4, 7'h37, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'h0000_1000, 32'd0, 2'd0);
    bd[16] = mk(3'd4, 7'h37, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'hFFFF_F000, 32'd0, 2'd0);
    bd[17] = mk(3'd4, 7'h37, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'h0000_0800, 32'd0, 2'd2);
    bd[18] = mk(3'd0, 7'h33, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'h0001_2345, 32'd0, 2'd0);
    bd[19] = mk(3'd6, 7'h13, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd3,         32'd0, 2'd1);
    bd[20] = mk(3'd7, 7'h13, 3'd1, 7'h20, 5'd4, 5'd5, 5'd6, 32'd4096,      32'd0, 2'd1);

    // reset
    rst_n = 1'b0; restart = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
    fmt = '0; cmd_op = '0; func3 = '0; func7 = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    #3;
    check("in_ready_in_reset", 64'(in_ready), 64'd1);
    check("mem_we_in_reset", 64'(mem_we), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check("rst_wrapped", 64'(wrapped), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_code", 64'(err_code), 64'd0);

    // back-to-back legal formats
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]);
      tick();
      check("tbl_we", 64'(mem_we), 64'd1);
      check("tbl_addr", 64'(mem_addr), 64'(i));
      check("tbl_word", 64'(mem_wdata), 64'(tbl[i].word));
    end
    in_valid = 1'b0;
    tick();
    check("tbl_idle_we", 64'(mem_we), 64'd0);

    // backpressure
    mem_ready = 1'b0;
    drive(tbl[0]);
    tick();
    drive(tbl[1]);
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      check("bp_addr", 64'(mem_addr), 64'd6);
      check("bp_data", 64'(mem_wdata), 64'(tbl[0].word));
    end
    mem_ready = 1'b1;
    tick();
    check("bp_next_addr", 64'(mem_addr), 64'd7);
    check("bp_next_data", 64'(mem_wdata), 64'(tbl[1].word));
    in_valid = 1'b0;
    tick();
    check("bp_drain_we", 64'(mem_we), 64'd0);

    // sticky first error
    drive(mk(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd4096, 32'd0, 2'd0));
    tick();
    check("err_range_we", 64'(mem_we), 64'd0);
    check("err_range_code", 64'({err, err_code}), 64'({1'b1, 2'd2}));
    drive(mk(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 32'd0, 2'd0));
    tick();
    check("err_align_keep", 64'({mem_we, err_code}), 64'({1'b0, 2'd2}));
    drive(mk(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 2'd0));
    tick();
    check("err_fmt_keep", 64'({mem_we, err_code}), 64'({1'b0, 2'd2}));
    drive(tbl[0]);
    tick();
    check("err_addr_held", 64'(mem_addr), 64'd8);
    in_valid = 1'b0;
    tick();

    // wrap on the 2-bit instance
    restart = 1'b1;
    tick();
    restart = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(tbl[i]);
      tick();
      check("wrap_addr", 64'(mem_addr_s), 64'(i % 4));
      check("wrap_word", 64'(mem_wdata_s), 64'(tbl[i].word));
      check("wrap_flag", 64'(wrapped_s), 64'(i >= 3));
    end
    in_valid = 1'b0;
    tick();

    // restart coincident with accept while a write is pending
    drive(mk(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 2'd0));
    tick();
    check("rs_err_set", 64'(err), 64'd1);
    mem_ready = 1'b0;
    drive(tbl[0]);
    tick();
    restart = 1'b1;
    mem_ready = 1'b1;
    drive(tbl[1]);
    check("rs_pending_addr", 64'(mem_addr), 64'd5);
    tick();
    restart = 1'b0;
    check("rs_new_addr", 64'(mem_addr), 64'd0);
    check("rs_new_word", 64'(mem_wdata), 64'(tbl[1].word));
    check("rs_err_clr", 64'({err, err_code}), 64'd0);
    check("rs_wrapped_clr", 64'(wrapped_s), 64'd0);
    drive(tbl[2]);
    tick();
    check("rs_next_addr", 64'(mem_addr), 64'd1);
    in_valid = 1'b0;
    tick();

    // boundary table, each entry applied with a restart so err_code reflects it
    for (int i = 0; i < 21; i++) begin
      restart = 1'b1;
      drive(bd[i]);
      tick();
      check("bd_code", 64'({err, err_code}), 64'({bd[i].code != 2'd0, bd[i].code}));
      check("bd_we", 64'(mem_we), 64'(bd[i].code == 2'd0));
      if (bd[i].code == 2'd0) check("bd_addr", 64'(mem_addr), 64'd0);
    end
    restart = 1'b0;
    in_valid = 1'b0;
    tick();

    // randomized run scored by the model
    for (int n = 0; n < 1500; n++) begin
      v = rand_vec();
      drive(v);
      in_valid = ($urandom_range(0, 9) < 7);
      mem_ready = ($urandom_range(0, 3) != 0);
      restart = ($urandom_range(0, 99) == 0);
      tick();
    end
    in_valid = 1'b0; restart = 1'b0; mem_ready = 1'b1;
    tick();
    tick();
    check("rand_drained", 64'(exp_q.size()), 64'd0);

    // async reset during backpressure
    drive(mk(3'd6, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd0, 32'd0, 2'd0));
    tick();
    check("ar_err_set", 64'(err), 64'd1);
    mem_ready = 1'b0;
    drive(tbl[0]);
    tick();
    in_valid = 1'b0;
    check("ar_pending", 64'(mem_we), 64'd1);
    #3 rst_n = 1'b0;
    exp_q.delete();
    m_cnt = '0; m_wrapped = 1'b0; m_err = 1'b0; m_code = 2'd0;
    #1;
    check("ar_we", 64'(mem_we), 64'd0);
    check("ar_err", 64'({err, err_code}), 64'd0);
    check("ar_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    mem_ready = 1'b1;
    drive(tbl[3]);
    tick();
    check("ar_first_addr", 64'(mem_addr), 64'd0);
    check("ar_first_word", 64'(mem_wdata), 64'(tbl[3].word));
    in_valid = 1'b0;
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
